mem_bus_arbiter: RTL and testbench
==================================

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have a single clock and a reset; reset is asynchronous and active-high.
REQ-002 Ports, one per line (name  direction  width  meaning):
- CLK  in  1  system clock; all state changes on rising edge
- RESET  in  1  asynchronous active-high reset
- dlx_req  in  1  requester 0 (DLX control MR|MW) transfer request
- dlx_wr  in  1  requester 0: 1=write, 0=read
- dlx_addr  in  32  requester 0 address
- dlx_wdata  in  32  requester 0 write data
- mon_req  in  1  requester 1 (monitor/debug) transfer request
- mon_wr  in  1  requester 1: 1=write, 0=read
- mon_addr  in  32  requester 1 address
- mon_wdata  in  32  requester 1 write data
- ack_n  in  1  bus acknowledge, active-low
- bus_rdata  in  32  bus read data
- as_N  out  1  address strobe, active-low
- wr_N  out  1  write strobe, active-low
- bus_addr  out  32  muxed address to bus
- bus_wdata  out  32  muxed write data to bus
- gnt  out  2  one-hot grant: bit0 DLX, bit1 monitor
- dlx_done  out  1  one-cycle completion pulse to DLX
- mon_done  out  1  one-cycle completion pulse to monitor
- rdata  out  32  registered read data of last completed read
- err  out  1  one-cycle timeout pulse, concurrent with done
- busy  out  1  high whenever state is not IDLE
- arb_state  out  2  state code: IDLE=00, ADDR=01, WAIT=10, DONE=11
REQ-003 Parameter: TIMEOUT, default 15, meaning max WAIT cycles without ack_n before abort.

Function
REQ-004 FSM SHALL have states IDLE, ADDR, WAIT, DONE, encoded as in arb_state.
REQ-005 IDLE: requests sampled only here; if any request is high, SHALL latch winner into gnt and wr direction, and go to ADDR.
REQ-006 Both requests high in IDLE: SHALL grant the requester not served last (round-robin); last_served resets to monitor, so DLX wins the first tie.
REQ-007 ADDR: as_N=0 for exactly one cycle; wr_N=0 for the whole of ADDR and WAIT if a write; bus_addr/bus_wdata driven from the granted requester from ADDR through DONE; unconditional transition to WAIT.
REQ-008 ack_n SHALL be ignored outside WAIT, including during the cycle in which as_N=0.
REQ-009 WAIT: ack_n=0 sampled at a rising edge SHALL move to DONE and, for reads, load bus_rdata into rdata on that same edge.
REQ-010 WAIT: 4-bit cycle counter cleared on entry; when count reaches TIMEOUT with ack_n still 1, SHALL move to DONE with err asserted in DONE; rdata unchanged.
REQ-011 DONE: granted requester's done=1 for one cycle, wr_N=1, as_N=1; update last_served; return to IDLE; gnt clears on entry to IDLE.
REQ-012 Latency: request high at edge k (IDLE) -> as_N=0 in cycle k+1 -> WAIT from k+2 -> ack sampled at edge m -> done high in cycle m+1 -> IDLE at m+2.
REQ-013 Requesters SHALL hold req, wr, addr, wdata until done; a request still high in IDLE after done starts a new transfer (subject to REQ-006).
REQ-014 Request dropped before grant: ignored, no bus activity; request change during ADDR/WAIT/DONE: no effect on current transfer.
REQ-015 When gnt=00, bus_addr and bus_wdata SHALL be 0.

Reset
REQ-016 RESET=1 SHALL immediately force state IDLE, as_N=1, wr_N=1, gnt=00, dlx_done=0, mon_done=0, err=0, busy=0, rdata=0, counter=0, last_served=monitor.
REQ-017 RESET mid-transfer SHALL abort it without a done pulse; first transfer after release starts from IDLE.

Verification
REQ-018 DLX read: dlx_req=1, dlx_wr=0, dlx_addr=0x0000A000; ack_n=0 on 3rd WAIT cycle with bus_rdata=0x01230123 -> as_N low one cycle, wr_N=1, rdata=0x01230123, dlx_done one cycle, gnt=01.
REQ-019 Monitor write: mon_req=1, mon_wr=1, mon_wdata=0x00112233 -> wr_N=0 through ADDR+WAIT, bus_wdata=0x00112233, mon_done pulse, gnt=10, rdata unchanged.
REQ-020 Tie: both requests held high after reset -> grants DLX, monitor, DLX in order, each with its done pulse.
REQ-021 Timeout: DLX read, ack_n held 1 -> after 15 WAIT cycles DONE with err=1 and dlx_done=1, rdata unchanged, then IDLE.
REQ-022 Early ack: ack_n=0 during ADDR only -> ignored, FSM stays in WAIT.
REQ-023 Reset during WAIT: RESET=1 for 2 cycles -> as_N=wr_N=1, gnt=00, no done pulse; subsequent DLX read completes normally.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Two-requester memory bus arbiter: DLX control vs. monitor/debug port.
// Round-robin on ties, one transfer in flight, WAIT timeout with err pulse.
module mem_bus_arbiter #(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        dlx_req,
   input  logic        dlx_wr,
   input  logic [31:0] dlx_addr,
   input  logic [31:0] dlx_wdata,
   input  logic        mon_req,
   input  logic        mon_wr,
   input  logic [31:0] mon_addr,
   input  logic [31:0] mon_wdata,
   input  logic        ack_n,
   input  logic [31:0] bus_rdata,
   output logic        as_N,
   output logic        wr_N,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   output logic [1:0]  gnt,
   output logic        dlx_done,
   output logic        mon_done,
   output logic [31:0] rdata,
   output logic        err,
   output logic        busy,
   output logic [1:0]  arb_state
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      ADDR = 2'b01,
      WAIT = 2'b10,
      DONE = 2'b11
   } state_t;

   localparam logic [3:0] CNT_MAX = 4'(TIMEOUT - 1);

   state_t      state_q, state_d;
   logic [1:0]  gnt_q, gnt_d;
   logic        wr_q, wr_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        to_q, to_d;
   logic        last_q, last_d;
   logic        pick_mon;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q <= IDLE;
         gnt_q   <= 2'b00;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         cnt_q   <= '0;
         to_q    <= 1'b0;
         last_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         cnt_q   <= cnt_d;
         to_q    <= to_d;
         last_q  <= last_d;
      end
   end

   // last_q=1 means the monitor was served last, so DLX wins a tie
   assign pick_mon = mon_req & (~dlx_req | ~last_q);

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      wr_d    = wr_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      cnt_d   = cnt_q;
      to_d    = to_q;
      last_d  = last_q;
      unique case (state_q)
         IDLE: begin
            if (dlx_req | mon_req) begin
               gnt_d   = pick_mon ? 2'b10 : 2'b01;
               wr_d    = pick_mon ? mon_wr : dlx_wr;
               addr_d  = pick_mon ? mon_addr : dlx_addr;
               wdata_d = pick_mon ? mon_wdata : dlx_wdata;
               to_d    = 1'b0;
               state_d = ADDR;
            end
         end
         ADDR: begin
            cnt_d   = '0;
            state_d = WAIT;
         end
         WAIT: begin
            if (!ack_n) begin
               state_d = DONE;
               if (!wr_q) rdata_d = bus_rdata;
            end else if (cnt_q == CNT_MAX) begin
               state_d = DONE;
               to_d    = 1'b1;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         DONE: begin
            last_d  = gnt_q[1];
            gnt_d   = 2'b00;
            to_d    = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign as_N      = (state_q != ADDR);
   assign wr_N      = ~(wr_q & ((state_q == ADDR) | (state_q == WAIT)));
   assign bus_addr  = (gnt_q != 2'b00) ? addr_q : '0;
   assign bus_wdata = (gnt_q != 2'b00) ? wdata_q : '0;
   assign gnt       = gnt_q;
   assign dlx_done  = (state_q == DONE) & gnt_q[0];
   assign mon_done  = (state_q == DONE) & gnt_q[1];
   assign err       = (state_q == DONE) & to_q;
   assign rdata     = rdata_q;
   assign busy      = (state_q != IDLE);
   assign arb_state = state_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: directed transfers queue their
// expected outcome, a negedge monitor checks each done pulse against it.
module tb_mem_bus_arbiter;

   logic        CLK = 1'b0;
   logic        RESET;
   logic        dlx_req, dlx_wr, mon_req, mon_wr, ack_n;
   logic [31:0] dlx_addr, dlx_wdata, mon_addr, mon_wdata, bus_rdata;
   logic        as_N, wr_N, dlx_done, mon_done, err, busy;
   logic [31:0] bus_addr, bus_wdata, rdata;
   logic [1:0]  gnt, arb_state;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [1:0]  gnt;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic        err;
      int          waits;
   } exp_t;

   exp_t sb[$];

   int   ack_dly = 0;
   logic early_ack = 1'b0;
   int   wcnt = 0;

   mem_bus_arbiter #(.TIMEOUT(15)) dut (
      .CLK(CLK), .RESET(RESET),
      .dlx_req(dlx_req), .dlx_wr(dlx_wr),
      .dlx_addr(dlx_addr), .dlx_wdata(dlx_wdata),
      .mon_req(mon_req), .mon_wr(mon_wr),
      .mon_addr(mon_addr), .mon_wdata(mon_wdata),
      .ack_n(ack_n), .bus_rdata(bus_rdata),
      .as_N(as_N), .wr_N(wr_N),
      .bus_addr(bus_addr), .bus_wdata(bus_wdata),
      .gnt(gnt), .dlx_done(dlx_done), .mon_done(mon_done),
      .rdata(rdata), .err(err), .busy(busy), .arb_state(arb_state)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   // Bus slave: ack in the ack_dly-th WAIT cycle (0 = never)
   always @(negedge CLK) begin
      if (arb_state == 2'b10) begin
         wcnt++;
         ack_n = (ack_dly != 0 && wcnt == ack_dly) ? 1'b0 : 1'b1;
      end else begin
         wcnt  = 0;
         ack_n = (early_ack && arb_state == 2'b01) ? 1'b0 : 1'b1;
      end
   end

   int          m_as, m_waits;
   logic [1:0]  m_gnt;
   logic [31:0] m_addr, m_wdata;
   logic        m_wrn, m_wrbad;

   always @(negedge CLK) begin
      if (RESET) begin
         m_as = 0; m_waits = 0; m_gnt = 2'b00;
         m_addr = '0; m_wdata = '0; m_wrn = 1'b1; m_wrbad = 1'b0;
      end else begin
         if (!as_N) m_as++;
         if (arb_state == 2'b01) begin
            m_gnt = gnt; m_addr = bus_addr;
            m_wdata = bus_wdata; m_wrn = wr_N;
         end
         if (arb_state == 2'b10) begin
            m_waits++;
            if (wr_N !== m_wrn) m_wrbad = 1'b1;
         end
         if (err && !(dlx_done || mon_done))
            chk("err_without_done", 32'(err), 32'd0);
         if (dlx_done || mon_done) begin
            if (sb.size() == 0) begin
               chk("unexpected_done", {30'd0, mon_done, dlx_done}, 32'd0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("done_bits", {30'd0, mon_done, dlx_done}, {30'd0, e.gnt});
               chk("gnt_addr", {30'd0, m_gnt}, {30'd0, e.gnt});
               chk("gnt_done", {30'd0, gnt}, {30'd0, e.gnt});
               chk("bus_addr", m_addr, e.addr);
               chk("bus_wdata", m_wdata, e.wdata);
               chk("wr_N_addr", 32'(m_wrn), 32'(!e.wr));
               chk("wr_N_steady", 32'(m_wrbad), 32'd0);
               chk("wr_N_done", 32'(wr_N), 32'd1);
               chk("as_N_cycles", 32'(m_as), 32'd1);
               chk("wait_cycles", 32'(m_waits), 32'(e.waits));
               chk("err", 32'(err), 32'(e.err));
               chk("rdata", rdata, e.rdata);
            end
            m_as = 0; m_waits = 0; m_wrbad = 1'b0;
         end
      end
   end

   task automatic wait_done(input int n, input string nm);
      int seen = 0;
      for (int i = 0; i < 200 && seen < n; i++) begin
         @(negedge CLK);
         if (dlx_done || mon_done) seen++;
      end
      chk(nm, 32'(seen), 32'(n));
   endtask

   task automatic push(input logic [1:0] g, input logic w,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] rd, input logic e_err,
                       input int waits);
      exp_t e;
      e.gnt = g; e.wr = w; e.addr = a; e.wdata = wd;
      e.rdata = rd; e.err = e_err; e.waits = waits;
      sb.push_back(e);
   endtask

   task automatic xfer(input logic m, input logic w,
                       input logic [31:0] a, input logic [31:0] wd,
                       input int dly, input logic [31:0] brd,
                       input logic early, input logic e_err,
                       input logic [31:0] e_rd, input int e_w);
      push(m ? 2'b10 : 2'b01, w, a, wd, e_rd, e_err, e_w);
      @(negedge CLK);
      ack_dly = dly; bus_rdata = brd; early_ack = early;
      if (m) begin
         mon_req = 1'b1; mon_wr = w; mon_addr = a; mon_wdata = wd;
      end else begin
         dlx_req = 1'b1; dlx_wr = w; dlx_addr = a; dlx_wdata = wd;
      end
      wait_done(1, "xfer_done");
      dlx_req = 1'b0; mon_req = 1'b0; early_ack = 1'b0;
      @(negedge CLK);
      chk("idle_after_done", {30'd0, arb_state}, 32'd0);
   endtask

   initial begin
      RESET = 1'b1;
      dlx_req = 0; dlx_wr = 0; dlx_addr = '0; dlx_wdata = '0;
      mon_req = 0; mon_wr = 0; mon_addr = '0; mon_wdata = '0;
      bus_rdata = '0;
      repeat (2) @(negedge CLK);
      chk("rst_as_N", 32'(as_N), 32'd1);
      chk("rst_wr_N", 32'(wr_N), 32'd1);
      chk("rst_gnt", {30'd0, gnt}, 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_state", {30'd0, arb_state}, 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_bus_addr", bus_addr, 32'd0);
      RESET = 1'b0;
      @(negedge CLK);

      // Tie right after reset: DLX, monitor, DLX
      push(2'b01, 1'b0, 32'h100, 32'h0, 32'h55AA55AA, 1'b0, 1);
      push(2'b10, 1'b0, 32'h200, 32'h0, 32'h55AA55AA, 1'b0, 1);
      push(2'b01, 1'b0, 32'h100, 32'h0, 32'h55AA55AA, 1'b0, 1);
      ack_dly = 1; bus_rdata = 32'h55AA55AA;
      dlx_wr = 0; dlx_addr = 32'h100; dlx_wdata = 0;
      mon_wr = 0; mon_addr = 32'h200; mon_wdata = 0;
      dlx_req = 1'b1; mon_req = 1'b1;
      wait_done(3, "tie_done");
      dlx_req = 1'b0; mon_req = 1'b0;
      @(negedge CLK);
      chk("tie_idle", {30'd0, arb_state}, 32'd0);

      // DLX read, ack in 3rd WAIT cycle
      xfer(0, 0, 32'h0000A000, 32'h0, 3, 32'h01230123, 0, 0,
           32'h01230123, 3);
      // Monitor write, rdata unchanged
      xfer(1, 1, 32'h00000040, 32'h00112233, 2, 32'hFFFF0000, 0, 0,
           32'h01230123, 2);
      // Timeout: 15 WAIT cycles, err, rdata unchanged
      xfer(0, 0, 32'h0000B000, 32'h0, 0, 32'hDEADBEEF, 0, 1,
           32'h01230123, 15);
      // ack during ADDR ignored
      xfer(0, 0, 32'h0000C000, 32'h0, 2, 32'h0A0B0C0D, 1, 0,
           32'h0A0B0C0D, 2);

      // Reset while a DLX write sits in WAIT
      @(negedge CLK);
      ack_dly = 0;
      dlx_req = 1'b1; dlx_wr = 1'b1;
      dlx_addr = 32'h0000E000; dlx_wdata = 32'hCAFEF00D;
      begin
         int n = 0;
         while (arb_state != 2'b10 && n < 20) begin
            @(negedge CLK);
            n++;
         end
         chk("reach_wait", {30'd0, arb_state}, 32'd2);
      end
      @(negedge CLK);
      chk("wr_N_in_wait", 32'(wr_N), 32'd0);
      RESET = 1'b1;
      dlx_req = 1'b0;
      #1;
      chk("arst_as_N", 32'(as_N), 32'd1);
      chk("arst_wr_N", 32'(wr_N), 32'd1);
      chk("arst_gnt", {30'd0, gnt}, 32'd0);
      chk("arst_state", {30'd0, arb_state}, 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_rdata", rdata, 32'd0);
      chk("arst_done", {30'd0, mon_done, dlx_done}, 32'd0);
      repeat (2) @(negedge CLK);
      RESET = 1'b0;
      @(negedge CLK);
      xfer(0, 0, 32'h0000D000, 32'h0, 1, 32'h13579BDF, 0, 0,
           32'h13579BDF, 1);

      repeat (3) @(negedge CLK);
      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
